// File: rtl/usr_ctrl_if.sv
// Command handshake and USR drive bundle between a command source and usr_ctrl.
// master = command source, slave = usr_ctrl.
interface usr_ctrl_if #(
   parameter int unsigned CNT_W = 4
);
   logic             cmd_valid;
   logic             cmd_ready;
   logic [1:0]       cmd_op;
   logic [CNT_W-1:0] cmd_count;
   logic [7:0]       cmd_data;
   logic [1:0]       usr_select;
   logic [7:0]       usr_data_in;
   logic             usr_sl_ser;
   logic             usr_sr_ser;
   logic             busy;
   logic             done;

   modport master (
      output cmd_valid, cmd_op, cmd_count, cmd_data,
      input  cmd_ready, usr_select, usr_data_in, usr_sl_ser, usr_sr_ser, busy, done
   );

   modport slave (
      input  cmd_valid, cmd_op, cmd_count, cmd_data,
      output cmd_ready, usr_select, usr_data_in, usr_sl_ser, usr_sr_ser, busy, done
   );
endinterface

// File: rtl/usr_ctrl.sv
// Command sequencer driving the universal shift register pins cycle by cycle.
// Optional abort input enabled by defining USR_CTRL_ABORT_EN.
//
// state    | meaning
// ---------+-----------------------------------------------
// ST_IDLE  | waiting for a command, cmd_ready=1
// ST_LOAD  | one parallel-load cycle on the USR
// ST_SHIFT | issuing serial bits, one per cycle
// ST_HOLD  | USR held for the commanded number of cycles
// ST_DONE  | one-cycle completion pulse
module usr_ctrl #(
   parameter int unsigned CNT_W = 4
) (
   input  logic         clock,
   input  logic         reset,
`ifdef USR_CTRL_ABORT_EN
   input  logic         abort,
`endif
   usr_ctrl_if.slave    bus
);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_LOAD,
      ST_SHIFT,
      ST_HOLD,
      ST_DONE
   } state_t;

   localparam logic [1:0] OP_SL   = 2'b00;
   localparam logic [1:0] OP_SR   = 2'b01;
   localparam logic [1:0] OP_LOAD = 2'b10;
   localparam logic [1:0] OP_HOLD = 2'b11;

   state_t           state_q, state_d;
   logic [1:0]       op_q, op_d;
   logic [CNT_W-1:0] remain_q, remain_d;
   logic [7:0]       data_q, data_d;
   logic [2:0]       idx_q, idx_d;

   logic [1:0]       sel_q, sel_d;
   logic [7:0]       din_q, din_d;
   logic             sl_q, sl_d;
   logic             sr_q, sr_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;

   logic             accept;
   logic             abort_req;

`ifdef USR_CTRL_ABORT_EN
   assign abort_req = abort;
`else
   assign abort_req = 1'b0;
`endif

   assign accept = bus.cmd_valid && (state_q == ST_IDLE);

   // Next-state and command registers. remain counts down to the last issue cycle;
   // idx is 3 bits wide so it wraps around the byte on its own.
   always_comb begin
      state_d  = state_q;
      op_d     = op_q;
      remain_d = remain_q;
      data_d   = data_q;
      idx_d    = idx_q;
      unique case (state_q)
         ST_IDLE: begin
            if (accept) begin
               op_d     = bus.cmd_op;
               remain_d = bus.cmd_count;
               data_d   = bus.cmd_data;
               idx_d    = 3'd0;
               if (bus.cmd_op == OP_LOAD) begin
                  state_d = ST_LOAD;
               end else if (bus.cmd_count == '0) begin
                  state_d = ST_DONE;
               end else if (bus.cmd_op == OP_HOLD) begin
                  state_d = ST_HOLD;
               end else begin
                  state_d = ST_SHIFT;
               end
            end
         end
         ST_LOAD: begin
            state_d = ST_DONE;
         end
         ST_SHIFT: begin
            idx_d    = idx_q + 3'd1;
            remain_d = remain_q - CNT_W'(1);
            if (remain_q == CNT_W'(1)) begin
               state_d = ST_DONE;
            end
         end
         ST_HOLD: begin
            remain_d = remain_q - CNT_W'(1);
            if (remain_q == CNT_W'(1)) begin
               state_d = ST_DONE;
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      if (abort_req && ((state_q == ST_LOAD) || (state_q == ST_SHIFT) || (state_q == ST_HOLD))) begin
         state_d = ST_DONE;
      end
   end

   // Outputs are decoded from the next state so they appear the cycle after the edge.
   always_comb begin
      sel_d  = OP_HOLD;
      din_d  = 8'h00;
      sl_d   = 1'b0;
      sr_d   = 1'b0;
      busy_d = (state_d != ST_IDLE);
      done_d = (state_d == ST_DONE);
      unique case (state_d)
         ST_LOAD: begin
            sel_d = OP_LOAD;
            din_d = data_d;
         end
         ST_SHIFT: begin
            sel_d = op_d;
            if (op_d == OP_SL) begin
               sl_d = data_d[idx_d];
            end else if (op_d == OP_SR) begin
               sr_d = data_d[idx_d];
            end
         end
         default: begin
            sel_d = OP_HOLD;
         end
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q  <= ST_IDLE;
         op_q     <= OP_HOLD;
         remain_q <= '0;
         data_q   <= 8'h00;
         idx_q    <= 3'd0;
         sel_q    <= OP_HOLD;
         din_q    <= 8'h00;
         sl_q     <= 1'b0;
         sr_q     <= 1'b0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         op_q     <= op_d;
         remain_q <= remain_d;
         data_q   <= data_d;
         idx_q    <= idx_d;
         sel_q    <= sel_d;
         din_q    <= din_d;
         sl_q     <= sl_d;
         sr_q     <= sr_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
      end
   end

   assign bus.cmd_ready   = (state_q == ST_IDLE);
   assign bus.usr_select  = sel_q;
   assign bus.usr_data_in = din_q;
   assign bus.usr_sl_ser  = sl_q;
   assign bus.usr_sr_ser  = sr_q;
   assign bus.busy        = busy_q;
   assign bus.done        = done_q;

endmodule

// File: tb/tb_usr_ctrl.sv
// Self-checking bench for usr_ctrl: command table, corner-case sequences and
// random commands checked against a cycle-trace model plus a USR behavioural model.
module tb_usr_ctrl;

   typedef struct packed {
      logic [1:0] sel;
      logic [7:0] din;
      logic       sl;
      logic       sr;
      logic       busy;
      logic       done;
      logic       ready;
   } obs_t;

   typedef struct {
      logic [1:0] op;
      logic [3:0] cnt;
      logic [7:0] data;
      int         exp_len;
      logic [7:0] exp_usr;
   } vec_t;

   localparam obs_t IDLE_OBS = '{sel: 2'b11, din: 8'h00, sl: 1'b0, sr: 1'b0,
                                 busy: 1'b0, done: 1'b0, ready: 1'b1};

   logic clock = 1'b0;
   logic reset;
`ifdef USR_CTRL_ABORT_EN
   logic abort;
`endif
   logic [7:0] usr_q;
   logic [7:0] usr_exp;
   int n_checks = 0;
   int n_pass   = 0;
   vec_t vecs[9];

   always #5 clock = ~clock;

   usr_ctrl_if #(.CNT_W(4)) bus ();

   usr_ctrl #(.CNT_W(4)) dut (
      .clock (clock),
      .reset (reset),
`ifdef USR_CTRL_ABORT_EN
      .abort (abort),
`endif
      .bus   (bus)
   );

   // Downstream universal shift register: 00 shift left, 01 shift right, 10 load, 11 hold.
   always_ff @(posedge clock) begin
      case (bus.usr_select)
         2'b00:   usr_q <= {usr_q[6:0], bus.usr_sl_ser};
         2'b01:   usr_q <= {bus.usr_sr_ser, usr_q[7:1]};
         2'b10:   usr_q <= bus.usr_data_in;
         default: usr_q <= usr_q;
      endcase
   end

   function automatic obs_t dut_obs();
      obs_t o;
      o.sel   = bus.usr_select;
      o.din   = bus.usr_data_in;
      o.sl    = bus.usr_sl_ser;
      o.sr    = bus.usr_sr_ser;
      o.busy  = bus.busy;
      o.done  = bus.done;
      o.ready = bus.cmd_ready;
      return o;
   endfunction

   function automatic int model_len(input logic [1:0] op, input logic [3:0] cnt);
      if (op == 2'b10) return 2;
      if (cnt == 4'd0) return 1;
      return int'(cnt) + 1;
   endfunction

   // Expected outputs in the j-th cycle after the accepting edge.
   function automatic obs_t model_obs(input logic [1:0] op, input logic [3:0] cnt,
                                      input logic [7:0] data, input int j);
      obs_t o;
      int   len;
      logic b;
      o   = IDLE_OBS;
      len = model_len(op, cnt);
      if (j >= 1 && j <= len) begin
         o.busy  = 1'b1;
         o.ready = 1'b0;
         if (j == len) begin
            o.done = 1'b1;
         end else if (op == 2'b10) begin
            o.sel = 2'b10;
            o.din = data;
         end else if (op != 2'b11) begin
            o.sel = op;
            b = data[(j - 1) % 8];
            if (op == 2'b00) o.sl = b;
            else             o.sr = b;
         end
      end
      return o;
   endfunction

   function automatic logic [7:0] usr_apply(input logic [7:0] start, input logic [1:0] op,
                                            input int cnt, input logic [7:0] data);
      logic [7:0] r;
      r = start;
      if (op == 2'b10) return data;
      if (op == 2'b11) return r;
      for (int i = 0; i < cnt; i++) begin
         if (op == 2'b00) r = {r[6:0], data[i % 8]};
         else             r = {data[i % 8], r[7:1]};
      end
      return r;
   endfunction

   task automatic check_obs(input string name, input obs_t act, input obs_t exp);
      n_checks++;
      if (act !== exp) begin
         $display("FAIL %s: got sel=%b din=%h sl=%b sr=%b busy=%b done=%b rdy=%b, want sel=%b din=%h sl=%b sr=%b busy=%b done=%b rdy=%b",
                  name, act.sel, act.din, act.sl, act.sr, act.busy, act.done, act.ready,
                  exp.sel, exp.din, exp.sl, exp.sr, exp.busy, exp.done, exp.ready);
      end else begin
         n_pass++;
      end
   endtask

   task automatic check_val(input string name, input int act, input int exp);
      n_checks++;
      if (act !== exp) $display("FAIL %s: got %0d, want %0d", name, act, exp);
      else n_pass++;
   endtask

   // Presents one command, waits for acceptance, checks every cycle until idle again.
   task automatic run_cmd(input logic [1:0] op, input logic [3:0] cnt, input logic [7:0] data,
                          input string tag, output int done_at);
      int len;
      int t;
      done_at = -1;
      @(negedge clock);
      bus.cmd_valid = 1'b1;
      bus.cmd_op    = op;
      bus.cmd_count = cnt;
      bus.cmd_data  = data;
      t = 0;
      while (!bus.cmd_ready && t < 100) begin
         @(negedge clock);
         t++;
      end
      if (!bus.cmd_ready) begin
         n_checks++;
         $display("FAIL %s accept: cmd_ready got 0, want 1 within 100 cycles", tag);
         bus.cmd_valid = 1'b0;
         return;
      end
      len = model_len(op, cnt);
      for (int j = 1; j <= len + 1; j++) begin
         @(negedge clock);
         if (j == 1) bus.cmd_valid = 1'b0;
         check_obs(tag, dut_obs(), model_obs(op, cnt, data, j));
         if (bus.done && done_at < 0) done_at = j;
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout, want $finish");
      $fatal(1);
   end

   initial begin
      int done_at;
      logic [1:0] r_op;
      logic [3:0] r_cnt;
      logic [7:0] r_data;

      vecs[0] = '{2'b10, 4'd0,  8'hA5, 2,  8'hA5};
      vecs[1] = '{2'b10, 4'd7,  8'h00, 2,  8'h00};
      vecs[2] = '{2'b00, 4'd4,  8'h0B, 5,  8'h0D};
      vecs[3] = '{2'b10, 4'd0,  8'h00, 2,  8'h00};
      vecs[4] = '{2'b01, 4'd10, 8'h01, 11, 8'h40};
      vecs[5] = '{2'b00, 4'd0,  8'hFF, 1,  8'h40};
      vecs[6] = '{2'b11, 4'd3,  8'h55, 4,  8'h40};
      vecs[7] = '{2'b01, 4'd3,  8'h06, 4,  8'hC8};
      vecs[8] = '{2'b00, 4'd15, 8'h81, 16, 8'hC0};

      reset         = 1'b1;
      bus.cmd_valid = 1'b0;
      bus.cmd_op    = 2'b00;
      bus.cmd_count = 4'd0;
      bus.cmd_data  = 8'h00;
`ifdef USR_CTRL_ABORT_EN
      abort = 1'b0;
`endif
      repeat (3) @(negedge clock);
      check_obs("reset", dut_obs(), IDLE_OBS);
      reset = 1'b0;

      // Directed command table
      for (int v = 0; v < 9; v++) begin
         run_cmd(vecs[v].op, vecs[v].cnt, vecs[v].data, $sformatf("vec%0d", v), done_at);
         check_val($sformatf("vec%0d len", v), done_at, vecs[v].exp_len);
         check_val($sformatf("vec%0d usr", v), int'(usr_q), int'(vecs[v].exp_usr));
      end
      usr_exp = 8'hC0;

      // Back-pressure: valid held through a hold-3 command, next command waits for ready
      @(negedge clock);
      bus.cmd_valid = 1'b1;
      bus.cmd_op    = 2'b11;
      bus.cmd_count = 4'd3;
      bus.cmd_data  = 8'h00;
      for (int j = 1; j <= 4; j++) begin
         @(negedge clock);
         if (j == 1) begin
            bus.cmd_op    = 2'b00;
            bus.cmd_count = 4'd2;
            bus.cmd_data  = 8'h03;
         end
         check_obs($sformatf("bp busy%0d", j), dut_obs(), model_obs(2'b11, 4'd3, 8'h00, j));
      end
      @(negedge clock);
      check_obs("bp gap", dut_obs(), IDLE_OBS);
      for (int j = 1; j <= 3; j++) begin
         @(negedge clock);
         bus.cmd_valid = 1'b0;
         check_obs($sformatf("bp second%0d", j), dut_obs(), model_obs(2'b00, 4'd2, 8'h03, j));
      end
      @(negedge clock);
      check_obs("bp idle", dut_obs(), IDLE_OBS);
      usr_exp = usr_apply(usr_exp, 2'b00, 2, 8'h03);
      check_val("bp usr", int'(usr_q), int'(usr_exp));

      // Reset in the 3rd cycle of a count-8 shift-left
      @(negedge clock);
      bus.cmd_valid = 1'b1;
      bus.cmd_op    = 2'b00;
      bus.cmd_count = 4'd8;
      bus.cmd_data  = 8'hFF;
      for (int j = 1; j <= 3; j++) begin
         @(negedge clock);
         bus.cmd_valid = 1'b0;
         check_obs($sformatf("rst shift%0d", j), dut_obs(), model_obs(2'b00, 4'd8, 8'hFF, j));
      end
      reset = 1'b1;
      @(negedge clock);
      reset = 1'b0;
      check_obs("rst mid", dut_obs(), IDLE_OBS);
      for (int j = 0; j < 3; j++) begin
         @(negedge clock);
         check_obs("rst after", dut_obs(), IDLE_OBS);
      end
      usr_exp = usr_apply(usr_exp, 2'b00, 3, 8'hFF);
      check_val("rst usr", int'(usr_q), int'(usr_exp));

      // Reset wins over a same-edge accept
      @(negedge clock);
      bus.cmd_valid = 1'b1;
      bus.cmd_op    = 2'b10;
      bus.cmd_data  = 8'h3C;
      reset         = 1'b1;
      @(negedge clock);
      bus.cmd_valid = 1'b0;
      reset         = 1'b0;
      check_obs("rst accept", dut_obs(), IDLE_OBS);
      @(negedge clock);
      check_obs("rst accept2", dut_obs(), IDLE_OBS);
      check_val("rst accept usr", int'(usr_q), int'(usr_exp));

`ifdef USR_CTRL_ABORT_EN
      // Abort in cycle 2 of a count-6 shift-left
      @(negedge clock);
      bus.cmd_valid = 1'b1;
      bus.cmd_op    = 2'b00;
      bus.cmd_count = 4'd6;
      bus.cmd_data  = 8'h2A;
      for (int j = 1; j <= 2; j++) begin
         @(negedge clock);
         bus.cmd_valid = 1'b0;
         check_obs($sformatf("abort shift%0d", j), dut_obs(), model_obs(2'b00, 4'd6, 8'h2A, j));
      end
      abort = 1'b1;
      @(negedge clock);
      abort = 1'b0;
      check_obs("abort done", dut_obs(), '{sel: 2'b11, din: 8'h00, sl: 1'b0, sr: 1'b0,
                                            busy: 1'b1, done: 1'b1, ready: 1'b0});
      @(negedge clock);
      check_obs("abort idle", dut_obs(), IDLE_OBS);
      usr_exp = usr_apply(usr_exp, 2'b00, 2, 8'h2A);
      check_val("abort usr", int'(usr_q), int'(usr_exp));
`endif

      // Random commands against the model
      for (int n = 0; n < 40; n++) begin
         r_op   = 2'($urandom_range(0, 3));
         r_cnt  = 4'($urandom_range(0, 15));
         r_data = 8'($urandom);
         run_cmd(r_op, r_cnt, r_data, $sformatf("rnd%0d", n), done_at);
         check_val($sformatf("rnd%0d len", n), done_at, model_len(r_op, r_cnt));
         usr_exp = usr_apply(usr_exp, r_op, int'(r_cnt), r_data);
         check_val($sformatf("rnd%0d usr", n), int'(usr_q), int'(usr_exp));
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/usr_ctrl.md
# usr_ctrl

Command sequencer that sits directly upstream of the universal shift register (USR) in the user project area. It accepts one command at a time over a valid/ready handshake: parallel load, shift-left N, shift-right N, or hold N. It then drives the USR `select`, `data_in`, `sl_ser` and `sr_ser` inputs cycle by cycle, so firmware or the logic analyzer can issue whole operations instead of toggling USR pins every clock. It runs in the same clock domain as the USR, and its outputs connect to the USR inputs with no glue logic.

## Interface
Parameters:
- `CNT_W`, default 4: width of the shift/hold count. Maximum count is 2^CNT_W−1.

Ports:
- `clock`  in  1  system clock. All logic is on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `cmd_valid`  in  1  command present.
- `cmd_ready`  out  1  block can accept a command. Equals 1 only in IDLE.
- `cmd_op`  in  2  operation: 00 shift-left, 01 shift-right, 10 parallel load, 11 hold.
- `cmd_count`  in  CNT_W  number of shift/hold cycles. Ignored for load.
- `cmd_data`  in  8  load value (load), or serial bit source, LSB first (shifts).
- `usr_select`  out  2  drives USR `select`.
- `usr_data_in`  out  8  drives USR `data_in`.
- `usr_sl_ser`  out  1  drives USR `sl_ser`.
- `usr_sr_ser`  out  1  drives USR `sr_ser`.
- `busy`  out  1  command in progress (any state other than IDLE).
- `done`  out  1  one-cycle pulse when a command completes.
- `abort`  in  1  present only with `USR_CTRL_ABORT_EN`.

## Operation
- FSM states are IDLE, LOAD, SHIFT, HOLD and DONE.
- **Accept.** A command is accepted on a rising edge where `cmd_valid` and `cmd_ready` are both 1. On that edge the block latches `cmd_op`, `cmd_count` and `cmd_data`, and clears the bit index `idx` to 0.
- **IDLE to next state.**
  - op 10 goes to LOAD.
  - op 00 or 01 goes to SHIFT.
  - op 11 goes to HOLD.
  - Any op with count 0 (other than load) goes straight to DONE.
- **LOAD.** Lasts exactly 1 cycle.
  - `usr_select`=10 and `usr_data_in`=latched data.
  - Next state is DONE.
- **SHIFT.** Lasts exactly `count` cycles.
  - `usr_select` equals the latched op.
  - The serial bit is `data[idx mod 8]`. It drives `usr_sl_ser` for op 00 and `usr_sr_ser` for op 01. The unused serial line is 0.
  - `idx` increments each cycle. Counts above 8 wrap around the byte.
  - Leaves for DONE after the cycle with `idx`=count−1.
- **HOLD.** Lasts exactly `count` cycles with `usr_select`=11, then goes to DONE.
- **DONE.** Lasts 1 cycle.
  - `done`=1 and `usr_select`=11.
  - Next state is IDLE.
- **Default output values.**
  - `usr_select`=11 in IDLE and DONE.
  - `usr_data_in`=0 in every state except LOAD.
  - Both serial lines are 0 outside SHIFT.
- **Flow control.** Commands presented while busy are not accepted. The source must hold `cmd_valid` and the command fields stable until it sees `cmd_ready`.
- **Outputs are registered.** The `usr_*` outputs, `busy` and `done` all come from flops. `cmd_ready` is decoded from the state register.

## Timing
- **Accept and issue.** A command accepted at edge k drives its first USR-control cycle in cycle k+1. The USR captures that value at edge k+2.
- **Command length.** Each command occupies the block for its issue cycles plus 1 DONE cycle:
  - load: 2 cycles.
  - shift or hold with count N≥1: N+1 cycles.
  - count 0: 1 cycle (DONE only).
- **Throughput.** `cmd_ready` returns 1 in the cycle after DONE. The minimum spacing between accepts is therefore the command length plus 1.
- **Reset values.** After any edge with `reset`=1:
  - state is IDLE and `idx`=0.
  - `usr_select`=11, `usr_data_in`=0x00, `usr_sl_ser`=0, `usr_sr_ser`=0.
  - `busy`=0, `done`=0, `cmd_ready`=1.
- **Reset precedence.** Reset overrides everything, including mid-shift and a same-cycle accept. The partially issued command is dropped and no `done` pulse is produced.

## Configuration
- **Macro `USR_CTRL_ABORT_EN`.**
- **When defined.**
  - Adds the `abort` input, which is ignored in IDLE and DONE.
  - `abort`=1 on an edge in LOAD, SHIFT or HOLD forces the next state to DONE. The next cycle has `usr_select`=11 with both serial lines 0.
  - `done` still pulses once. No further serial bits are issued.
  - If `abort` and `reset` are both 1, reset wins.
- **When undefined.** The `abort` port does not exist, and commands always run to completion.

## Test plan
- **Parallel load.** Reset, then load with `cmd_data`=0xA5.
  - Expect exactly one cycle of `usr_select`=10 with `usr_data_in`=0xA5, then `done`.
  - USR `data_out`=0xA5 afterwards.
- **Shift-left.** Load 0x00, then shift-left with count 4 and data 0x0B.
  - Expect `usr_sl_ser` sequence 1,1,0,1.
  - USR `data_out`=0x0D; `done` 5 cycles after accept.
- **Shift-right with wrap.** Shift-right with count 10 and data 0x01.
  - Expect `usr_sr_ser` sequence 1,0,0,0,0,0,0,0,1,0 (index wraps after bit 7).
  - USR result is 0x40, starting from 0x00.
- **Count 0 and back-pressure.** Issue a count-0 shift.
  - Expect `done` in the cycle after accept, with `usr_select` never leaving 11.
  - Hold `cmd_valid` during `busy`: no second accept occurs until `cmd_ready`=1.
- **Reset mid-shift.** Assert `reset` in the 3rd cycle of a count-8 shift.
  - Expect all outputs at their reset values next cycle and no `done` pulse.
  - USR keeps the bits already shifted.
- **Abort (`USR_CTRL_ABORT_EN` only).** Pulse `abort` in cycle 2 of a count-6 shift-left.
  - Expect only 2 serial bits issued, then `done`=1 with `usr_select`=11.
  - `cmd_ready`=1 one cycle later.
